// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared types and constants for the synthesiser datapath: envelope state
// encoding, ROM address / sample widths, the offset-binary midpoint and the
// default phase-accumulator width.
// -----------------------------------------------------------------------------
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam int             ADDR_BITS          = 10;
  localparam int             SAMPLE_BITS        = 8;
  localparam logic [7:0]     MIDPOINT           = 8'd128;
  localparam int             PHASE_BITS_DEFAULT = 24;

endpackage

// File: rtl/sample_tick_gen.sv
// -----------------------------------------------------------------------------
// sample_tick_gen
// Free-running divider producing the audio sample-rate tick. The counter runs
// 0..CLOCK_DIV-1 and wraps; the tick is high for the whole cycle in which the
// count equals CLOCK_DIV-1, so the first tick after reset arrives on the
// CLOCK_DIV-th cycle.
//
// Ports:
//   i_clk   in   system clock
//   i_rst   in   synchronous active-high reset (count returns to 0)
//   o_tick  out  one-cycle sample tick, every CLOCK_DIV cycles
// -----------------------------------------------------------------------------
module sample_tick_gen #(
  parameter int CLOCK_DIV = 1042
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int            CW   = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/note_oscillator.sv
// -----------------------------------------------------------------------------
// note_oscillator
// DDS front end for the sine wavetable ROM. A phase accumulator advances by
// the tuning word on every sample tick and its top bits address the ROM. The
// ROM word returned one cycle later is re-centred around zero, scaled by a
// linear attack/sustain/release envelope amplitude and re-offset to produce
// one offset-binary sample per tick.
//
// Ports:
//   i_clk           in   system clock
//   i_rst           in   synchronous active-high reset
//   i_tuning_word   in   phase increment, sampled on tick cycles
//   i_note_start    in   one-cycle pulse: start / retrigger the note
//   i_note_stop     in   one-cycle pulse: release the note
//   o_address       out  ROM address (top bits of the phase register)
//   i_rom_data      in   ROM word for the address of the previous cycle
//   o_sample        out  scaled sample, offset binary, 128 = silence
//   o_sample_valid  out  one-cycle strobe, o_sample updated
//   o_busy          out  envelope is not IDLE
// -----------------------------------------------------------------------------
module note_oscillator
  import synth_pkg::*;
#(
  parameter int CLOCK_DIV    = 1042,
  parameter int PHASE_BITS   = PHASE_BITS_DEFAULT,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [PHASE_BITS-1:0]  i_tuning_word,
  input  logic                   i_note_start,
  input  logic                   i_note_stop,
  output logic [ADDR_BITS-1:0]   o_address,
  input  logic [SAMPLE_BITS-1:0] i_rom_data,
  output logic [SAMPLE_BITS-1:0] o_sample,
  output logic                   o_sample_valid,
  output logic                   o_busy
);

  // Offset-binary ROM word times unsigned amplitude, floored back to offset
  // binary. The 17-bit product covers -128*255 .. 127*255, so the result
  // spans 0..254 and never wraps.
  function automatic logic [SAMPLE_BITS-1:0] scale_sample(
    input logic [SAMPLE_BITS-1:0] data,
    input logic [7:0]             amp
  );
    logic signed [8:0]  c;
    logic signed [16:0] p;
    logic        [7:0]  s;
    c = $signed({1'b0, data}) - 9'sd128;
    p = 17'(c) * 17'($signed({1'b0, amp}));
    s = 8'(p >>> 8);
    return s + MIDPOINT;
  endfunction

  logic                  w_tick;
  env_state_t            r_state;
  logic [PHASE_BITS-1:0] r_phase;
  logic [7:0]            r_amp;
  logic [7:0]            w_amp_tick;
  logic [8:0]            w_att_sum;
  logic [8:0]            w_rel_diff;

  logic                  r_vld_p0;
  logic                  r_vld_p1;
  logic [7:0]            r_amp_p1;
  logic [SAMPLE_BITS-1:0] r_sample;
  logic                  r_sample_valid;

  sample_tick_gen #(
    .CLOCK_DIV (CLOCK_DIV)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  // Amplitude the envelope would take on the next tick edge, saturating at
  // both ends. The ninth bit is the carry / borrow that signals saturation.
  always_comb begin
    w_att_sum  = {1'b0, r_amp} + 9'(ATTACK_STEP);
    w_rel_diff = {1'b0, r_amp} - 9'(RELEASE_STEP);
    w_amp_tick = r_amp;
    case (r_state)
      ATTACK:  w_amp_tick = w_att_sum[8]  ? 8'hFF : w_att_sum[7:0];
      RELEASE: w_amp_tick = w_rel_diff[8] ? 8'h00 : w_rel_diff[7:0];
      default: w_amp_tick = r_amp;
    endcase
  end

  // Envelope FSM, amplitude register and phase accumulator. Note events move
  // the state on any cycle; amplitude and phase move only on ticks. Start has
  // priority over stop, and both have priority over the amplitude-driven
  // transitions, so a retrigger keeps phase and amp running without a click.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_amp   <= '0;
      r_phase <= '0;
    end else begin
      if (w_tick) begin
        r_amp   <= w_amp_tick;
        r_phase <= r_phase + i_tuning_word;
      end
      case (r_state)
        IDLE: begin
          // Phase stays parked at zero so every fresh note starts at address 0.
          r_phase <= '0;
          if (i_note_start) begin
            r_state <= ATTACK;
          end
        end
        ATTACK: begin
          if (i_note_start) begin
            r_state <= ATTACK;
          end else if (i_note_stop) begin
            r_state <= RELEASE;
          end else if (w_tick && (w_amp_tick == 8'hFF)) begin
            r_state <= SUSTAIN;
          end
        end
        SUSTAIN: begin
          if (i_note_start) begin
            r_state <= ATTACK;
          end else if (i_note_stop) begin
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          if (i_note_start) begin
            r_state <= ATTACK;
          end else if (w_tick && (w_amp_tick == 8'h00)) begin
            r_state <= IDLE;
            r_phase <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Align / scale pipeline. Valid bits are reset so a reset flushes any tick
  // still in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p0       <= 1'b0;
      r_vld_p1       <= 1'b0;
      r_amp_p1       <= '0;
      r_sample       <= MIDPOINT;
      r_sample_valid <= 1'b0;
    end else begin
      // p0: address and amp for this tick are in their registers.
      r_vld_p0 <= w_tick;
      // p1: ROM is registering the word; carry the tick's amp alongside it.
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) begin
        r_amp_p1 <= r_amp;
      end
      // p2: ROM word available, scale and publish.
      r_sample_valid <= r_vld_p1;
      if (r_vld_p1) begin
        r_sample <= scale_sample(i_rom_data, r_amp_p1);
      end
    end
  end

  assign o_address      = r_phase[PHASE_BITS-1 -: ADDR_BITS];
  assign o_sample       = r_sample;
  assign o_sample_valid = r_sample_valid;
  assign o_busy         = (r_state != IDLE);

endmodule
